// File: rtl/pipeline_controller_pkg.sv
// Shared pipeline definitions: controller state encoding, bubble constant, stage registers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipeline_controller_pkg;

  // Controller FSM encoding
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FAULT    = 2'd2
  } ctrl_state_t;

  // Bubble: an all-zero instruction word decodes as a NOP with every control bit clear
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Per-instruction control bits carried down the pipe
  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  // Stage register layouts; a flush loads the bubble form of each
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    ctrl_t       ctrl;
  } id_ex_t;

  typedef struct packed {
    logic [31:0] alu_res;
    logic [4:0]  rd;
    ctrl_t       ctrl;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] wb_dat;
    logic [4:0]  rd;
    ctrl_t       ctrl;
  } mem_wb_t;

endpackage

// File: rtl/pipeline_controller_hazard_detect.sv
// Load-use hazard comparator between the ID instruction and a load in EX.
// Latency: combinational, zero cycles.
// Backpressure: none; the result feeds the controller's stall decision.
// Ports: id_rs1/id_rs2 + id_use_rs1/id_use_rs2 (ID sources), ex_rd/ex_mem_read (EX load), load_use (hazard).
module hazard_detect (
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_read,
  output logic       load_use
);

  // x0 is hardwired zero, so a load targeting it never creates a dependency
  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));

endmodule

// File: rtl/pipeline_controller.sv
// Pipeline stall/flush controller with memory-wait timeout and performance counters.
// Latency: control outputs are combinational (zero-cycle); counters update on the next edge.
// Backpressure: mem_busy freezes PC..EX/MEM and bubbles MEM/WB; a stuck memory halts the core.
// Ports: clk, reset_n; ID/EX hazard inputs, ex_branch_taken, mem_busy; stage enables, flushes,
//        pc_redirect, halted; stall_cycles / flush_events counters (CNT_W bits, saturating).
module pipeline_controller
  import pipeline_controller_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             pc_redirect,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W:0] TIMEOUT_V = (WAIT_W + 1)'(MEM_TIMEOUT);

  ctrl_state_t       state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W:0]   busy_count;
  logic              timeout;
  logic              load_use;

  hazard_detect u_hazard_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .load_use    (load_use)
  );

  // busy_count is the 1-based index of the current busy cycle in the run
  assign busy_count = {1'b0, wait_cnt} + (WAIT_W + 1)'(1);
  assign timeout    = mem_busy && (busy_count >= TIMEOUT_V);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_RUN, ST_MEM_WAIT: begin
        if (mem_busy) state_nxt = timeout ? ST_FAULT : ST_MEM_WAIT;
        else          state_nxt = ST_RUN;
      end
      ST_FAULT: state_nxt = ST_FAULT;
      default:  state_nxt = ST_RUN;
    endcase
  end

  // RUN and MEM_WAIT share outputs: MEM_WAIT only differs in that it came from a freeze.
  // A branch seen while frozen is not remembered; EX is held so it is still asserted on exit.
  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    pc_redirect  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    halted       = 1'b0;
    if (state == ST_FAULT) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      mem_wb_flush = 1'b1;
      halted       = 1'b1;
    end else if (mem_busy) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (ex_branch_taken) begin
      pc_redirect  = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
    end else if (load_use) begin
      // Hold PC and IF/ID, push a bubble into ID/EX so the load moves ahead alone
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_flush  = 1'b1;
    end
  end

  // Wait counter never exceeds MEM_TIMEOUT: reaching it moves to FAULT, where it is frozen
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (state != ST_FAULT) begin
      wait_cnt <= mem_busy ? busy_count[WAIT_W-1:0] : '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else if (state != ST_FAULT) begin
      if (!pc_en && (stall_cycles != '1)) stall_cycles <= stall_cycles + CNT_W'(1);
      if (pc_redirect && (flush_events != '1)) flush_events <= flush_events + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_controller.sv
module tb_pipeline_controller;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic       id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
  logic       ex_mem_read = 1'b0, ex_branch_taken = 1'b0, mem_busy = 1'b0;
  logic       pc_en, if_id_en, id_ex_en, ex_mem_en, pc_redirect;
  logic       if_id_flush, id_ex_flush, mem_wb_flush, halted;
  logic [3:0] stall_cycles, flush_events;

  always #5 clk = ~clk;

  pipeline_controller #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .mem_busy(mem_busy),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .pc_redirect(pc_redirect), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .mem_wb_flush(mem_wb_flush), .halted(halted),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  // {pc_en,if_id_en,id_ex_en,ex_mem_en, pc_redirect,if_id_flush,id_ex_flush,mem_wb_flush, halted}
  localparam logic [8:0] RUNV   = 9'b1111_0000_0;
  localparam logic [8:0] STALL  = 9'b0011_0010_0;
  localparam logic [8:0] BRANCH = 9'b1111_1110_0;
  localparam logic [8:0] FREEZE = 9'b0000_0001_0;
  localparam logic [8:0] FAULTV = 9'b0000_0111_1;

  typedef struct {
    string      name;
    logic [8:0] ctrl;
    logic [3:0] stall;
    logic [3:0] flush;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  logic drv_done = 1'b0;

  // Drive one cycle of inputs just after the edge and queue what the DUT must show this cycle
  task automatic step(input string name, input logic rst, input logic busy, input logic br,
                      input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic u1, input logic u2,
                      input logic [8:0] ctrl, input int s, input int f);
    exp_t e;
    @(posedge clk);
    #1;
    reset_n = rst; mem_busy = busy; ex_branch_taken = br; ex_mem_read = mr;
    ex_rd = rd; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    e.name = name; e.ctrl = ctrl; e.stall = 4'(s); e.flush = 4'(f);
    exp_q.push_back(e);
  endtask

  task automatic idle(input string name, input logic rst, input logic [8:0] ctrl,
                      input int s, input int f);
    step(name, rst, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, ctrl, s, f);
  endtask

  // Monitor: one expectation is consumed per cycle, sampled mid-cycle
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        logic [8:0] got;
        e = exp_q.pop_front();
        got = {pc_en, if_id_en, id_ex_en, ex_mem_en, pc_redirect,
               if_id_flush, id_ex_flush, mem_wb_flush, halted};
        checks++;
        if (got !== e.ctrl) begin
          failures++;
          $display("FAIL %s ctrl: got %b want %b", e.name, got, e.ctrl);
        end
        checks++;
        if (stall_cycles !== e.stall || flush_events !== e.flush) begin
          failures++;
          $display("FAIL %s counters: got stall=%0d flush=%0d want stall=%0d flush=%0d",
                   e.name, stall_cycles, flush_events, e.stall, e.flush);
        end
      end
    end
  end

  initial begin
    idle("reset0", 0, RUNV, 0, 0);
    idle("reset1", 0, RUNV, 0, 0);
    idle("idle", 1, RUNV, 0, 0);
    step("load_use_rs1", 1, 0, 0, 1, 5'd5, 5'd5, 5'd0, 1, 0, STALL, 0, 0);
    idle("after_bubble", 1, RUNV, 1, 0);
    step("rd_zero", 1, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 0, RUNV, 1, 0);
    step("load_use_rs2", 1, 0, 0, 1, 5'd7, 5'd3, 5'd7, 0, 1, STALL, 1, 0);
    step("rs2_unused", 1, 0, 0, 1, 5'd7, 5'd3, 5'd7, 0, 0, RUNV, 2, 0);
    step("branch_hazard", 1, 0, 1, 1, 5'd5, 5'd5, 5'd0, 1, 0, BRANCH, 2, 0);
    idle("after_branch", 1, RUNV, 2, 1);
    step("memwait1", 1, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, FREEZE, 2, 1);
    step("memwait2", 1, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, FREEZE, 3, 1);
    step("memwait3", 1, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, FREEZE, 4, 1);
    step("memwait_exit_br", 1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, BRANCH, 5, 1);
    idle("after_memwait", 1, RUNV, 5, 2);
    step("busy_over_hazard", 1, 1, 0, 1, 5'd5, 5'd5, 5'd0, 1, 0, FREEZE, 5, 2);
    step("exit_load_use", 1, 0, 0, 1, 5'd5, 5'd5, 5'd0, 1, 0, STALL, 6, 2);
    idle("after_exit", 1, RUNV, 7, 2);
    for (int i = 0; i < 4; i++)
      step("timeout_busy", 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, FREEZE, 7 + i, 2);
    step("fault_busy", 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, FAULTV, 11, 2);
    step("fault_branch", 1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, FAULTV, 11, 2);
    idle("fault_sticky", 1, FAULTV, 11, 2);
    idle("fault_reset", 0, RUNV, 0, 0);
    for (int i = 0; i < 20; i++)
      step("saturate", 1, 0, 0, 1, 5'd9, 5'd9, 5'd0, 1, 0, STALL, (i < 15) ? i : 15, 0);
    idle("sat_hold", 1, RUNV, 15, 0);
    idle("reset2", 0, RUNV, 0, 0);
    step("mw_busy1", 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, FREEZE, 0, 0);
    step("mw_busy2", 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, FREEZE, 1, 0);
    step("mw_reset", 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, FREEZE, 0, 0);
    for (int i = 0; i < 3; i++)
      step("mw_rebusy", 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, FREEZE, i, 0);
    idle("mw_no_fault", 1, RUNV, 3, 0);
    idle("mw_final", 1, RUNV, 3, 0);
    drv_done = 1'b1;
  end

  initial begin
    int waited;
    waited = 0;
    while (!drv_done && waited < 5000) begin
      @(posedge clk);
      waited++;
    end
    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    checks++;
    if (!drv_done || exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain: driver_done=%0b pending=%0d want driver_done=1 pending=0",
               drv_done, exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_controller.md
PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255: maximum consecutive mem_busy cycles tolerated before a fault is declared.
REQ-002 Parameter CNT_W, default 32: width of each performance counter.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
REQ-006 id_use_rs1, id_use_rs2  in  1 each  the ID instruction actually reads that source.
REQ-007 ex_rd  in  5  destination register of the instruction in EX.
REQ-008 ex_mem_read  in  1  the EX instruction is a load.
REQ-009 ex_branch_taken  in  1  branch/jump resolved taken in EX this cycle.
REQ-010 mem_busy  in  1  data memory has not completed this cycle.
REQ-011 pc_en, if_id_en, id_ex_en, ex_mem_en  out  1 each  stage-register load enables (1 = advance).
REQ-012 pc_redirect  out  1  PC mux selects the EX branch target.
REQ-013 if_id_flush, id_ex_flush, mem_wb_flush  out  1 each  load a bubble (all-zero instruction/controls) into that register.
REQ-014 halted  out  1  controller is in FAULT.
REQ-015 stall_cycles, flush_events  out  CNT_W each  performance counters.

Function
REQ-016 The FSM SHALL have states RUN, MEM_WAIT and FAULT, held in a registered state variable; all control outputs SHALL be combinational from the state and current inputs, giving zero-cycle response.
REQ-017 Load-use hazard = ex_mem_read & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
REQ-018 Default in RUN with no event: every enable =1, every flush =0, pc_redirect=0.
REQ-019 RUN with mem_busy=1: pc_en, if_id_en, id_ex_en, ex_mem_en =0, mem_wb_flush=1, all other flushes =0, pc_redirect=0; next state MEM_WAIT.
REQ-020 RUN with mem_busy=0 and ex_branch_taken=1: pc_redirect=1, if_id_flush=1, id_ex_flush=1, all enables =1; load-use is ignored.
REQ-021 RUN with mem_busy=0, no branch, load-use hazard: pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=1; exactly one bubble per hazard, because the bubble clears the EX condition on the next cycle.
REQ-022 Priority SHALL be mem_busy > ex_branch_taken > load-use.
REQ-023 MEM_WAIT: outputs as REQ-019 while mem_busy=1; on the first cycle with mem_busy=0, behave as RUN for that cycle (REQ-020/021 apply) and return to RUN.
REQ-024 A branch taken while frozen is not latched; it is honoured when mem_busy falls, because EX is held.
REQ-025 A wait counter SHALL count consecutive mem_busy cycles from 1; when it reaches MEM_TIMEOUT with mem_busy still 1, next state is FAULT; it clears on mem_busy=0.
REQ-026 FAULT: halted=1, all enables =0, if_id_flush, id_ex_flush and mem_wb_flush =1, pc_redirect=0; FAULT is left only by reset.
REQ-027 stall_cycles SHALL increment on every cycle with pc_en=0; flush_events SHALL increment on every cycle with pc_redirect=1; both saturate at all-ones and stop counting in FAULT.

Reset
REQ-028 While reset_n=0 the controller SHALL set state RUN, wait counter 0 and both counters 0, and hold halted=0; reset asserted mid-MEM_WAIT or in FAULT returns to RUN asynchronously.
REQ-029 Release SHALL be synchronised to clk by the surrounding design; the controller assumes no reset-recovery glitches.

Structure
REQ-030 State encoding and the bubble/NOP constant SHALL live in the shared pipeline package, alongside the stage register definitions.
REQ-031 The hazard comparator (REQ-017) SHALL be a sub-module named hazard_detect; the saturating counters are instantiated inline.

Verification
REQ-032 Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> one cycle of pc_en=0, if_id_en=0, id_ex_flush=1; stall_cycles 0->1.
REQ-033 Rd zero: same as REQ-032 with ex_rd=0 -> no stall, all enables =1.
REQ-034 Branch and hazard together: ex_branch_taken=1 with the REQ-032 hazard -> pc_redirect=1, if_id_flush=1, id_ex_flush=1, pc_en=1; flush_events +1.
REQ-035 Memory wait: mem_busy high for 3 cycles, with ex_branch_taken=1 held throughout -> 3 frozen cycles with mem_wb_flush=1, then a redirect on the 4th cycle; stall_cycles +3.
REQ-036 Timeout: MEM_TIMEOUT=4, mem_busy held high -> halted=1 after the 4th busy cycle, remaining high indefinitely; reset_n pulse -> halted=0 and counters 0.
REQ-037 Saturation: CNT_W=4 with 20 consecutive stall cycles -> stall_cycles holds at 15.
